// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter defaults, weak-state
// constants, branch-kind encodings and address field extraction helpers.
package bp_pkg;

    localparam int unsigned CNT_W_DEF = 2;

    // Branch kind encoding carried on upd_jump_i
    localparam logic BR_COND = 1'b0;
    localparam logic BR_JUMP = 1'b1;

    // Weakly-taken counter value for a given counter width
    function automatic int unsigned bp_weak_t(input int unsigned cnt_w);
        return 32'd1 << (cnt_w - 1);
    endfunction

    // Weakly-not-taken counter value for a given counter width
    function automatic int unsigned bp_weak_nt(input int unsigned cnt_w);
        return (32'd1 << (cnt_w - 1)) - 32'd1;
    endfunction

    // Table index: word-address bits just above the byte offset
    function automatic logic [63:0] bp_idx(input logic [63:0] addr, input int unsigned idx_w);
        logic [63:0] mask;
        mask = (64'd1 << idx_w) - 64'd1;
        return (addr >> 2) & mask;
    endfunction

    // Tag: everything above the index
    function automatic logic [63:0] bp_tag(input logic [63:0] addr, input int unsigned idx_w);
        return addr >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/bp_sat_cnt.sv
// Combinational saturating up/down counter step used by the BTB update path.
module bp_sat_cnt #(
    parameter int unsigned CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Step toward the outcome, holding at either end of the range
    always_comb begin
        cnt_o = cnt_i;
        if (inc_i) begin
            if (cnt_i != '1) cnt_o = cnt_i + CNT_W'(1);
        end else begin
            if (cnt_i != '0) cnt_o = cnt_i - CNT_W'(1);
        end
    end

endmodule

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Lookup is combinational on pc_i; training happens on the clock edge.
// Optional misprediction counter enabled by defining BP_STATS_EN.
module bp_btb
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_addr_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_jump_i,
    input  logic              upd_mispred_i,
    input  logic              flush_i,
    output logic [31:0]       mispred_cnt_o
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(bp_weak_t(CNT_W));
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'(bp_weak_nt(CNT_W));

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [ADDR_W-1:0]  target_d [ENTRIES];
    logic [CNT_W-1:0]   cnt_q    [ENTRIES];
    logic [CNT_W-1:0]   cnt_d    [ENTRIES];
    logic [ENTRIES-1:0] jump_q, jump_d;

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             lk_hit, upd_hit;
    logic [CNT_W-1:0] cnt_nxt;

    assign lk_idx  = IDX_W'(bp_idx(64'(pc_i), IDX_W));
    assign lk_tag  = TAG_W'(bp_tag(64'(pc_i), IDX_W));
    assign upd_idx = IDX_W'(bp_idx(64'(upd_pc_i), IDX_W));
    assign upd_tag = TAG_W'(bp_tag(64'(upd_pc_i), IDX_W));

    // Lookup reads pre-update state only; reset clears valid so it also misses
    always_comb begin
        lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken_o = lk_hit && (jump_q[lk_idx] || cnt_q[lk_idx][CNT_W-1]);
        pred_addr_o  = pred_taken_o ? target_q[lk_idx] : pc_i + ADDR_W'(4);
    end

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    bp_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sat_cnt (
        .cnt_i (cnt_q[upd_idx]),
        .inc_i (upd_taken_i),
        .cnt_o (cnt_nxt)
    );

    // Table next state: flush wins over a same-cycle update
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        jump_d   = jump_q;
        if (flush_i) begin
            valid_d = '0;
        end else if (upd_valid_i) begin
            if (upd_hit) begin
                cnt_d[upd_idx] = cnt_nxt;
                if (upd_taken_i) begin
                    target_d[upd_idx] = upd_target_i;
                    jump_d[upd_idx]   = (upd_jump_i == BR_JUMP);
                end
            end else if (upd_taken_i) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target_i;
                jump_d[upd_idx]   = (upd_jump_i == BR_JUMP);
                cnt_d[upd_idx]    = CNT_WEAK_T;
            end
        end
    end

    // Table storage with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            jump_q  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WEAK_NT;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            jump_q   <= jump_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] mispred_q, mispred_d;

    // Saturating count of mispredicted resolutions, ignoring flushed cycles
    always_comb begin
        mispred_d = mispred_q;
        if (upd_valid_i && upd_mispred_i && !flush_i && (mispred_q != '1)) begin
            mispred_d = mispred_q + 32'd1;
        end
    end

    // Statistics register, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mispred_q <= '0;
        else     mispred_q <= mispred_d;
    end

    assign mispred_cnt_o = mispred_q;
`else
    logic unused_mispred;
    assign unused_mispred = upd_mispred_i;
    assign mispred_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_bp_btb.sv
// Self-checking bench for bp_btb: directed vector table, hand sequences for
// same-cycle and reset corners, then random traffic against a reference model.
module tb_bp_btb;

    localparam int unsigned ENTRIES = 16;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned CNT_W   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = 32'h100;
    logic        pred_taken_o;
    logic [31:0] pred_addr_o;
    logic        upd_valid_i = 1'b0;
    logic [31:0] upd_pc_i = '0;
    logic        upd_taken_i = 1'b0;
    logic [31:0] upd_target_i = '0;
    logic        upd_jump_i = 1'b0;
    logic        upd_mispred_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] mispred_cnt_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bp_btb #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .pred_taken_o  (pred_taken_o),
        .pred_addr_o   (pred_addr_o),
        .upd_valid_i   (upd_valid_i),
        .upd_pc_i      (upd_pc_i),
        .upd_taken_i   (upd_taken_i),
        .upd_target_i  (upd_target_i),
        .upd_jump_i    (upd_jump_i),
        .upd_mispred_i (upd_mispred_i),
        .flush_i       (flush_i),
        .mispred_cnt_o (mispred_cnt_o)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // One clock edge; update strobes are single-cycle pulses
    task automatic tick();
        @(posedge clk);
        #1;
        upd_valid_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    task automatic drive(input logic uv, input logic [31:0] upc, input logic tk,
                         input logic [31:0] tgt, input logic jp, input logic mp,
                         input logic fl);
        upd_valid_i   = uv;
        upd_pc_i      = upc;
        upd_taken_i   = tk;
        upd_target_i  = tgt;
        upd_jump_i    = jp;
        upd_mispred_i = mp;
        flush_i       = fl;
    endtask

    // ---------------- reference model ----------------
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    bit          m_jump  [ENTRIES];
    longint      m_mis;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0;
            m_cnt[i]   = (1 << (CNT_W - 1)) - 1;
        end
        m_mis = 0;
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        int unsigned e;
        e = (pc / 4) % ENTRIES;
        return m_valid[e] && (m_tag[e] == pc / (4 * ENTRIES));
    endfunction

    function automatic bit model_taken(input logic [31:0] pc);
        int unsigned e;
        e = (pc / 4) % ENTRIES;
        return model_hit(pc) && (m_jump[e] || m_cnt[e] >= (1 << (CNT_W - 1)));
    endfunction

    function automatic logic [31:0] model_addr(input logic [31:0] pc);
        return model_taken(pc) ? m_tgt[(pc / 4) % ENTRIES] : pc + 32'd4;
    endfunction

    function automatic void model_update(input bit uv, input logic [31:0] upc, input bit tk,
                                         input logic [31:0] tgt, input bit jp, input bit mp,
                                         input bit fl);
        int unsigned e;
        int          cmax;
        e    = (upc / 4) % ENTRIES;
        cmax = (1 << CNT_W) - 1;
        if (fl) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
            return;
        end
        if (!uv) return;
        if (mp && m_mis < 64'hFFFF_FFFF) m_mis++;
        if (model_hit(upc)) begin
            if (tk) begin
                m_cnt[e]  = (m_cnt[e] < cmax) ? m_cnt[e] + 1 : cmax;
                m_tgt[e]  = tgt;
                m_jump[e] = jp;
            end else begin
                m_cnt[e] = (m_cnt[e] > 0) ? m_cnt[e] - 1 : 0;
            end
        end else if (tk) begin
            m_valid[e] = 1;
            m_tag[e]   = upc / (4 * ENTRIES);
            m_tgt[e]   = tgt;
            m_jump[e]  = jp;
            m_cnt[e]   = 1 << (CNT_W - 1);
        end
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        tk;
        logic [31:0] tgt;
        logic        jp;
        logic        mp;
        logic        fl;
        logic [31:0] lpc;
        logic        etk;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic uv, input logic [31:0] upc, input logic tk,
                       input logic [31:0] tgt, input logic jp, input logic mp, input logic fl,
                       input logic [31:0] lpc, input logic etk, input logic [31:0] eaddr);
        vec_t v;
        v.uv = uv; v.upc = upc; v.tk = tk; v.tgt = tgt; v.jp = jp; v.mp = mp; v.fl = fl;
        v.lpc = lpc; v.etk = etk; v.eaddr = eaddr;
        vq.push_back(v);
    endtask

    logic [31:0] exp_mis;

    initial begin
        // Reset state
        #1;
        check("reset_taken", {31'd0, pred_taken_o}, 32'd0);
        check("reset_addr", pred_addr_o, 32'h104);
        check("reset_mispred", mispred_cnt_o, 32'd0);
        #2 rst = 1'b0;

        // uv   upc           tk   tgt           jp   mp   fl   lpc           etk  eaddr
        add(1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h100,     1'b0, 32'h104);
        add(1'b1, 32'h100,    1'b1, 32'h80,     1'b0, 1'b1, 1'b0, 32'h100,     1'b1, 32'h80);
        add(1'b1, 32'h100,    1'b0, 32'h0,      1'b0, 1'b1, 1'b0, 32'h100,     1'b0, 32'h104);
        add(1'b1, 32'h100,    1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h100,     1'b0, 32'h104);
        add(1'b1, 32'h100,    1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h100,     1'b0, 32'h104);
        add(1'b1, 32'h100,    1'b1, 32'h80,     1'b0, 1'b1, 1'b0, 32'h100,     1'b0, 32'h104);
        add(1'b1, 32'h100,    1'b1, 32'h80,     1'b0, 1'b0, 1'b0, 32'h100,     1'b1, 32'h80);
        add(1'b1, 32'h100,    1'b1, 32'h80,     1'b0, 1'b0, 1'b0, 32'h100,     1'b1, 32'h80);
        add(1'b1, 32'h100,    1'b1, 32'h80,     1'b0, 1'b0, 1'b0, 32'h100,     1'b1, 32'h80);
        add(1'b1, 32'h100,    1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h100,     1'b1, 32'h80);
        add(1'b1, 32'h100,    1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h100,     1'b0, 32'h104);
        add(1'b1, 32'h140,    1'b1, 32'h200,    1'b0, 1'b1, 1'b0, 32'h140,     1'b1, 32'h200);
        add(1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h100,     1'b0, 32'h104);
        add(1'b1, 32'h20,     1'b1, 32'h400,    1'b1, 1'b0, 1'b0, 32'h20,      1'b1, 32'h400);
        add(1'b1, 32'h20,     1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h20,      1'b1, 32'h400);
        add(1'b1, 32'h20,     1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h20,      1'b1, 32'h400);
        add(1'b1, 32'h20,     1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h20,      1'b1, 32'h400);
        add(1'b1, 32'h300,    1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h300,     1'b0, 32'h304);
        add(1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h140,     1'b1, 32'h200);
        add(1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 1'b0, 32'h0);
        add(1'b1, 32'h300,    1'b1, 32'h500,    1'b0, 1'b1, 1'b1, 32'h300,     1'b0, 32'h304);
        add(1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h20,      1'b0, 32'h24);
        add(1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h140,     1'b0, 32'h144);

        foreach (vq[i]) begin
            drive(vq[i].uv, vq[i].upc, vq[i].tk, vq[i].tgt, vq[i].jp, vq[i].mp, vq[i].fl);
            tick();
            pc_i = vq[i].lpc;
            #1;
            check($sformatf("vec%0d_taken", i), {31'd0, pred_taken_o}, {31'd0, vq[i].etk});
            check($sformatf("vec%0d_addr", i), pred_addr_o, vq[i].eaddr);
        end

`ifdef BP_STATS_EN
        exp_mis = 32'd4;
`else
        exp_mis = 32'd0;
`endif
        check("vec_mispred_cnt", mispred_cnt_o, exp_mis);

        // Same-cycle lookup and update: lookup sees the old (flushed) table
        drive(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
        pc_i = 32'h100;
        #1;
        check("samecyc_pre_taken", {31'd0, pred_taken_o}, 32'd0);
        check("samecyc_pre_addr", pred_addr_o, 32'h104);
        tick();
        check("samecyc_post_taken", {31'd0, pred_taken_o}, 32'd1);
        check("samecyc_post_addr", pred_addr_o, 32'h80);

        // Reset mid-run: outputs drop at once and the pending update is lost
        drive(1'b1, 32'h100, 1'b1, 32'h90, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_taken", {31'd0, pred_taken_o}, 32'd0);
        check("midrst_addr", pred_addr_o, 32'h104);
        check("midrst_mispred", mispred_cnt_o, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("postrst_taken", {31'd0, pred_taken_o}, 32'd0);
        check("postrst_addr", pred_addr_o, 32'h104);

        // Random traffic against the reference model
        model_reset();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] lpc, upc, tgt;
            bit uv, tk, jp, mp, fl;
            lpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            upc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            tgt = $urandom;
            uv  = ($urandom_range(0, 1) == 1);
            tk  = ($urandom_range(0, 3) != 0);
            jp  = ($urandom_range(0, 3) == 0);
            mp  = ($urandom_range(0, 1) == 1);
            fl  = ($urandom_range(0, 31) == 0);
            drive(uv, upc, tk, tgt, jp, mp, fl);
            pc_i = lpc;
            #1;
            check($sformatf("rnd%0d_taken", n), {31'd0, pred_taken_o}, {31'd0, model_taken(lpc)});
            check($sformatf("rnd%0d_addr", n), pred_addr_o, model_addr(lpc));
            tick();
            model_update(uv, upc, tk, tgt, jp, mp, fl);
        end

`ifdef BP_STATS_EN
        exp_mis = m_mis[31:0];
`else
        exp_mis = 32'd0;
`endif
        check("rnd_mispred_cnt", mispred_cnt_o, exp_mis);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_btb.md
Name: bp_btb

Overview:
- Parametrised successor to the core's single-cycle static branch predictor.
- Direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- Lookup is combinational on the fetch PC and feeds pc_reg/if_id in the same cycle. Training is synchronous, driven by branch resolution in ex.
- Replaces the instruction-decode-based guess with learned targets for JAL and conditional branches.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, >= 2
ADDR_W, 32, instruction address width
CNT_W, 2, direction counter width; >= 1
IDX_W, $clog2(ENTRIES), derived index width; not overridable
TAG_W, ADDR_W-IDX_W-2, derived tag width; not overridable

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
pc_i  in  ADDR_W  fetch address for lookup
pred_taken_o  out  1  predicted taken
pred_addr_o  out  ADDR_W  predicted next fetch address
upd_valid_i  in  1  resolved-branch update strobe from ex
upd_pc_i  in  ADDR_W  address of the resolved branch
upd_taken_i  in  1  actual branch outcome
upd_target_i  in  ADDR_W  actual target address
upd_jump_i  in  1  1 = unconditional (JAL), 0 = conditional
upd_mispred_i  in  1  ex detected a misprediction
flush_i  in  1  invalidate the whole table (jtag PC reset, fence.i)
mispred_cnt_o  out  32  misprediction count (optional feature)

Behaviour:
- Address split: idx = addr[IDX_W+1:2]; tag = addr[ADDR_W-1:IDX_W+2]; addr[1:0] ignored.
- Entry contents: valid, tag, target, cnt[CNT_W-1:0], jump.
- Reset (rst=1, asynchronous): all valid=0, all cnt=WEAK_NT (2^(CNT_W-1)-1), mispred_cnt_o=0.
  - Outputs while in reset: pred_taken_o=0, pred_addr_o=pc_i+4.
  - Reset mid-training discards any pending update.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag match.
  - pred_taken_o = hit && (jump || cnt[CNT_W-1]).
  - pred_addr_o = pred_taken_o ? target : pc_i+4. Addition wraps modulo 2^ADDR_W.
- Update (posedge clk, upd_valid_i=1, flush_i=0):
  - Hit, taken: cnt saturating +1 (caps at 2^CNT_W-1); target <= upd_target_i; jump <= upd_jump_i.
  - Hit, not taken: cnt saturating -1 (floor 0); target unchanged.
  - Miss, taken: allocate or overwrite. valid=1, tag, target, jump loaded; cnt=WEAK_T (2^(CNT_W-1)).
  - Miss, not taken: no change.
- flush_i=1: all valid cleared at the next edge. Flush has priority over a simultaneous update; that update is dropped. Counters are not reset.
- Same-cycle lookup and update to the same index: lookup sees pre-update contents; no bypass. The new contents are visible the cycle after the edge.
- No stall input. The owner gates upd_valid_i so that each resolved branch produces exactly one pulse.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined: 32-bit register. Increments on each edge with upd_valid_i && upd_mispred_i && !flush_i. Saturates at 0xFFFFFFFF. Cleared only by rst.
- Undefined: mispred_cnt_o tied to 0; no counter flops.

Decomposition:
- Package bp_pkg holds:
  - CNT_W default
  - WEAK_T / WEAK_NT constant functions
  - BR_COND=0 / BR_JUMP=1 encodings
  - tag/index extraction functions
- Sub-module bp_sat_cnt: combinational saturating inc/dec with CNT_W parameter, used by the update path.
- Table storage stays as flops in bp_btb (asynchronous reset needed on valid bits).

Test Plan (ENTRIES=16, CNT_W=2):
1. Release rst, pc_i=0x100 -> pred_taken_o=0, pred_addr_o=0x104. Assert rst mid-run -> outputs return to this state immediately.
2. Update pc=0x100, taken, target=0x80, jump=0 -> next cycle pc_i=0x100 gives pred_taken_o=1, pred_addr_o=0x80 (cnt=2). Same-cycle lookup during the update still gives 0x104.
3. Counter saturation on 0x100:
   - Two not-taken updates -> cnt 1 then 0; lookup gives 0x104. A third not-taken update leaves cnt=0.
   - Four taken updates -> cnt 1, 2, 3, 3.
4. Alias: taken update pc=0x140 (idx 0), target=0x200 -> lookup 0x140 gives 0x200; lookup 0x100 misses and gives 0x104.
5. JAL entry: update pc=0x20, taken, jump=1, target=0x400, then 3 not-taken updates -> pred_taken_o stays 1.
6. flush_i together with a taken update to 0x300 -> all lookups miss and 0x300 is not allocated. With BP_STATS_EN, 5 mispredict strobes (one during flush excluded) -> mispred_cnt_o=4; without the macro -> 0.
